// File: rtl/cipher_sched_if.sv
// Handshake bundle between the block scheduler, receive/transmit queues and cipher core.
interface cipher_sched_if;
  logic       key_ready;
  logic       enc_req;
  logic       dec_req;
  logic       tx_full;
  logic       abort;
  logic       grant_enc;
  logic       grant_dec;
  logic       core_load;
  logic       core_mode;
  logic       core_round_en;
  logic [3:0] round_idx;
  logic       result_enq;
  logic       busy;

  modport slave (
    input  key_ready, enc_req, dec_req, tx_full, abort,
    output grant_enc, grant_dec, core_load, core_mode, core_round_en,
           round_idx, result_enq, busy
  );

  modport master (
    output key_ready, enc_req, dec_req, tx_full, abort,
    input  grant_enc, grant_dec, core_load, core_mode, core_round_en,
           round_idx, result_enq, busy
  );
endinterface

// File: rtl/cipher_sched.sv
// Single-block cipher scheduler: round-robin enc/dec arbitration, load, NUM_ROUNDS
// core rounds with direction-dependent subkey index, then back-pressured result enqueue.
module cipher_sched #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic          clk,
  input  logic          n_reset,
  cipher_sched_if.slave bus
);
  localparam logic [3:0] LAST = 4'(NUM_ROUNDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_OUTPUT} state_t;

  state_t     r_state, w_next;
  logic [3:0] r_cnt;
  logic       r_mode;
  logic       r_last;    // 1 = last grant went to decrypt
  logic       w_start, w_sel;
  logic       w_grant_enc, w_grant_dec, w_load, w_round_en, w_enq, w_busy;
  logic [3:0] w_idx;

  // Contested requests go to the type not granted last.
  always_comb begin
    w_sel = ~r_last;
    if (bus.enc_req && !bus.dec_req)      w_sel = 1'b0;
    else if (!bus.enc_req && bus.dec_req) w_sel = 1'b1;
  end

  assign w_start = (r_state == S_IDLE) && bus.key_ready && (bus.enc_req || bus.dec_req);

  always_comb begin
    w_next      = r_state;
    w_grant_enc = 1'b0;
    w_grant_dec = 1'b0;
    w_load      = 1'b0;
    w_round_en  = 1'b0;
    w_enq       = 1'b0;
    w_busy      = 1'b1;
    w_idx       = 4'd0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (w_start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_grant_enc = ~r_mode;
        w_grant_dec = r_mode;
        w_next      = bus.abort ? S_IDLE : S_ROUND;
      end
      S_ROUND: begin
        w_round_en = 1'b1;
        w_idx      = r_mode ? (LAST - r_cnt) : r_cnt;
        if (bus.abort)          w_next = S_IDLE;
        else if (r_cnt == LAST) w_next = S_OUTPUT;
      end
      S_OUTPUT: begin
        if (bus.abort) begin
          w_next = S_IDLE;
        end else if (!bus.tx_full) begin
          w_enq  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Selection is latched on the IDLE->LOAD edge so mode is stable from LOAD onward.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_mode  <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_mode <= w_sel;
        r_last <= w_sel;
      end
      if (r_state == S_LOAD)       r_cnt <= 4'd0;
      else if (r_state == S_ROUND) r_cnt <= r_cnt + 4'd1;
    end
  end

  assign bus.grant_enc     = w_grant_enc;
  assign bus.grant_dec     = w_grant_dec;
  assign bus.core_load     = w_load;
  assign bus.core_mode     = r_mode;
  assign bus.core_round_en = w_round_en;
  assign bus.round_idx     = w_idx;
  assign bus.result_enq    = w_enq;
  assign bus.busy          = w_busy;
endmodule

// File: doc/cipher_sched.md
CIPHER_SCHED -- requirements
Module: cipher_sched

Interface
REQ-001 Parameter NUM_ROUNDS, default 16, number of cipher core rounds per block (legal 2..16).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 n_reset  input  1  reset, asynchronous, active-low.
REQ-004 key_ready  input  1  level; key generator has finished and key is loaded in core.
REQ-005 enc_req  input  1  level; receive path holds a block awaiting encryption.
REQ-006 dec_req  input  1  level; receive path holds a block awaiting decryption.
REQ-007 tx_full  input  1  transmit FIFO full.
REQ-008 abort  input  1  synchronous one-cycle abort of the block in flight.
REQ-009 grant_enc  output  1  one-cycle pulse; encryption requester granted and must dequeue its block.
REQ-010 grant_dec  output  1  one-cycle pulse; decryption requester granted and must dequeue its block.
REQ-011 core_load  output  1  core latches the input block this cycle.
REQ-012 core_mode  output  1  0 = encrypt, 1 = decrypt; held stable from LOAD until return to IDLE.
REQ-013 core_round_en  output  1  core executes one round this cycle.
REQ-014 round_idx  output  4  subkey index for the current round.
REQ-015 result_enq  output  1  one-cycle pulse; enqueue core result into transmit FIFO.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL use the states IDLE, LOAD, ROUND, OUTPUT.
REQ-018 IDLE -> LOAD when key_ready=1 and (enc_req or dec_req); otherwise stay in IDLE; no grant is issued while key_ready=0.
REQ-019 Arbitration SHALL be round-robin: if both requests are high, grant the type not granted last; if one is high, grant it; last_grant SHALL update on every grant.
REQ-020 In LOAD (exactly one cycle): assert core_load and the selected grant pulse; latch core_mode; clear round counter; next state ROUND.
REQ-021 In ROUND: assert core_round_en every cycle for exactly NUM_ROUNDS cycles; 4-bit counter runs 0..NUM_ROUNDS-1.
REQ-022 round_idx SHALL equal counter when core_mode=0 and NUM_ROUNDS-1-counter when core_mode=1; round_idx=0 outside ROUND.
REQ-023 ROUND -> OUTPUT in the cycle after counter = NUM_ROUNDS-1.
REQ-024 In OUTPUT: if tx_full=0, assert result_enq for one cycle and go to IDLE; if tx_full=1, hold OUTPUT with result_enq=0 and retry every cycle.
REQ-025 Latency: request sampled in IDLE at cycle t -> grant/core_load at t+1 -> rounds t+2..t+1+NUM_ROUNDS -> result_enq at t+2+NUM_ROUNDS when tx_full=0.
REQ-026 Only one block SHALL be in flight; requests arriving outside IDLE are ignored until IDLE is re-entered.
REQ-027 abort=1 in LOAD, ROUND or OUTPUT SHALL force IDLE next cycle with no result_enq; abort in IDLE has no effect; abort wins over tx_full=0 in OUTPUT.
REQ-028 key_ready falling after LOAD SHALL NOT disturb the block in flight.
REQ-029 grant_enc and grant_dec SHALL never be high together; result_enq SHALL never coincide with core_round_en.

Reset
REQ-030 While n_reset=0: state=IDLE, counter=0, core_mode=0, last_grant=decrypt (first contested grant goes to encrypt), all outputs 0.
REQ-031 Reset asserted mid-operation SHALL discard the block immediately, with no result_enq after release.

Verification
REQ-032 key_ready=1, enc_req pulse, tx_full=0, NUM_ROUNDS=16 -> grant_enc at t+1, round_idx 0..15 at t+2..t+17, result_enq at t+18.
REQ-033 dec_req only -> core_mode=1, round_idx 15 down to 0, grant_dec single pulse.
REQ-034 enc_req and dec_req held high after reset -> grants alternate enc, dec, enc, dec over four blocks.
REQ-035 tx_full=1 for 5 cycles on entry to OUTPUT -> result_enq delayed exactly 5 cycles, busy stays 1.
REQ-036 abort at 3rd ROUND cycle -> IDLE next cycle, no result_enq, next request granted normally.
REQ-037 key_ready=0 with requests pending -> no grant; key_ready rises -> grant next cycle; n_reset low mid-ROUND -> all outputs 0 at once.
